// File: rtl/mul_div_pkg.sv
// Shared definitions for the multi-cycle multiply/divide engine.
// Op codes use the same 5-bit encoding as the ALU.
// Holds the engine's state enum and its default operand width.
package mul_div_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [4:0] OP_MFLO = 5'd11;
  localparam logic [4:0] OP_MFHI = 5'd12;
  localparam logic [4:0] OP_DIV  = 5'd13;
  localparam logic [4:0] OP_MULT = 5'd14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } md_state_e;

endpackage

// File: rtl/mul_div_unit_step.sv
// One iteration of the engine: shift-add (multiply) or trial-subtract (divide).
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module md_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic               div_mode_i,
  input  logic [2*WIDTH-1:0] acc_i,   // mul: product accumulator; div: partial remainder in [WIDTH:0]
  input  logic [WIDTH-1:0]   opb_i,   // mul: multiplicand; div: divisor
  input  logic [WIDTH-1:0]   shf_i,   // mul: multiplier (LSB consumed); div: dividend in / quotient out
  output logic [2*WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0]   shf_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] rem_diff;
  logic           rem_ge;

  // Multiply: add multiplicand into the upper half when the current multiplier bit is set.
  assign sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, (shf_i[0] ? opb_i : '0)};

  // Divide: bring the next dividend bit into the remainder and try to subtract the divisor.
  // The remainder is always below the divisor, so its top bit is never needed before the shift.
  assign rem_sh   = {acc_i[WIDTH-1:0], shf_i[WIDTH-1]};
  assign rem_ge   = (rem_sh >= {1'b0, opb_i});
  assign rem_diff = rem_sh - {1'b0, opb_i};

  // Select the step result for the active mode.
  always_comb begin
    acc_o = '0;
    shf_o = '0;
    if (div_mode_i) begin
      acc_o = {{(WIDTH-1){1'b0}}, (rem_ge ? rem_diff : rem_sh)};
      shf_o = {shf_i[WIDTH-2:0], rem_ge};
    end else begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
      shf_o = {1'b0, shf_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/DIV engine owning HI/LO; optional signed mode under SIGNED_MD_EN.
// Latency: busy for WIDTH cycles after the start edge, done pulses the following cycle.
// Backpressure: start is ignored while busy (no queueing); accepted again in the done cycle.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SIGNED_MD_EN
  input  logic             sgn,
`endif
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rdata
);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   shf_q, shf_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               sgn_w;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] step_acc;
  logic [WIDTH-1:0]   step_shf;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic               last_iter;

`ifdef SIGNED_MD_EN
  assign sgn_w = sgn;
`else
  assign sgn_w = 1'b0;
`endif

  // Iterate on magnitudes; signs are restored when the result is written.
  assign a_mag = (sgn_w && a[WIDTH-1]) ? -a : a;
  assign b_mag = (sgn_w && b[WIDTH-1]) ? -b : b;

  md_iter_step #(.WIDTH(WIDTH)) u_step (
    .div_mode_i (state_q == DIV),
    .acc_i      (acc_q),
    .opb_i      (opb_q),
    .shf_i      (shf_q),
    .acc_o      (step_acc),
    .shf_o      (step_shf)
  );

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign prod      = neg_res_q ? -step_acc : step_acc;
  assign quo       = neg_res_q ? -step_shf : step_shf;
  assign rem       = neg_rem_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];

  // Next-state logic: accept ops from IDLE/FIN, iterate, write HI/LO on the last step.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    shf_d     = shf_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (start && (op == OP_MULT || op == OP_DIV)) begin
          acc_d     = '0;
          cnt_d     = '0;
          neg_res_d = sgn_w & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = sgn_w & a[WIDTH-1];
          if (op == OP_MULT) begin
            state_d = MUL;
            opb_d   = a_mag;
            shf_d   = b_mag;
          end else begin
            state_d = DIV;
            opb_d   = b_mag;
            shf_d   = a_mag;
          end
        end
      end
      MUL, DIV: begin
        acc_d = step_acc;
        shf_d = step_shf;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d = FIN;
          cnt_d   = '0;
          if (state_q == MUL) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      shf_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      shf_q     <= shf_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy  = (state_q == MUL) || (state_q == DIV);
  assign done  = (state_q == FIN);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign rdata = (op == OP_MFLO) ? lo_q :
                 (op == OP_MFHI) ? hi_q : '0;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: scoreboard of expected {hi,lo} per issued op.
// Signed cases are exercised only when SIGNED_MD_EN is defined.
// Inputs driven on the falling edge, outputs sampled on the falling edge or #1 after it.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  op = 5'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo, rdata;
`ifdef SIGNED_MD_EN
  logic        sgn = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef SIGNED_MD_EN
    .sgn   (sgn),
`endif
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo),
    .rdata (rdata)
  );

  function automatic logic [63:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input bit s);
    logic [31:0] q, r;
    if (o == 5'd14) begin
      if (s) return longint'(int'(x)) * longint'(int'(y));
      return {32'd0, x} * {32'd0, y};
    end
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (s) begin
      q = int'(x) / int'(y);
      r = int'(x) % int'(y);
    end else begin
      q = x / y;
      r = x % y;
    end
    return {r, q};
  endfunction

  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input bit s, input bit now);
    if (!now) @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
`ifdef SIGNED_MD_EN
    sgn = s;
`endif
    exp_q.push_back(model(o, x, y, s));
    @(negedge clk);
    start = 1'b0; op = 5'd0;
    a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(input string nm, input int exp_cyc);
    int cyc = 0;
    int bc = 0;
    logic [63:0] e;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy === 1'b1) bc++;
      cyc++;
      @(negedge clk);
    end
    n_cmp++;
    if (cyc != exp_cyc) begin n_err++; $display("FAIL %s latency: got %0d cycles, want %0d", nm, cyc, exp_cyc); end
    n_cmp++;
    if (bc != exp_cyc) begin n_err++; $display("FAIL %s busy_len: got %0d, want %0d", nm, bc, exp_cyc); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy_at_done: got %b, want 0", nm, busy); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
    n_cmp++;
    if (hi !== e[63:32]) begin n_err++; $display("FAIL %s hi: got %h, want %h", nm, hi, e[63:32]); end
    n_cmp++;
    if (lo !== e[31:0]) begin n_err++; $display("FAIL %s lo: got %h, want %h", nm, lo, e[31:0]); end
    last_hi = e[63:32];
    last_lo = e[31:0];
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL reset busy/done: got %b, want 00", {busy, done}); end
    n_cmp++;
    if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL reset hi/lo: got %h, want 0", {hi, lo}); end
    rst = 1'b0;
    @(negedge clk);
    op = 5'd11;
    #1;
    n_cmp++;
    if (rdata !== 32'd0) begin n_err++; $display("FAIL reset rdata: got %h, want 0", rdata); end
    op = 5'd0;
  endtask

  task automatic test_mult;
    issue(5'd14, 32'd12, 32'd4, 1'b0, 1'b0);
    wait_done("mult_12x4", 32);
    op = 5'd11; #1;
    n_cmp++;
    if (rdata !== 32'd48) begin n_err++; $display("FAIL mflo: got %h, want 30", rdata); end
    op = 5'd12; #1;
    n_cmp++;
    if (rdata !== 32'd0) begin n_err++; $display("FAIL mfhi: got %h, want 0", rdata); end
    op = 5'd7; #1;
    n_cmp++;
    if (rdata !== 32'd0) begin n_err++; $display("FAIL rdata_other_op: got %h, want 0", rdata); end
    op = 5'd0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL done_one_cycle: got %b, want 00", {busy, done}); end
    issue(5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_done("mult_max", 32);
  endtask

  task automatic test_div;
    issue(5'd13, 32'd13, 32'd4, 1'b0, 1'b0);
    wait_done("div_13_4", 32);
    issue(5'd13, 32'd7, 32'd0, 1'b0, 1'b0);
    wait_done("div_by_zero", 32);
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++) begin
      if (i[0]) issue(5'd13, $urandom, $urandom_range(1, 100000), 1'b0, 1'b0);
      else      issue(5'd14, $urandom, $urandom, 1'b0, 1'b0);
      wait_done("random", 32);
    end
  endtask

  task automatic test_start_while_busy;
    logic [31:0] prev_lo;
    prev_lo = last_lo;
    issue(5'd14, 32'd12, 32'd4, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 5'd13; a = 32'd100; b = 32'd10;
    @(negedge clk);
    start = 1'b0; op = 5'd11;
    #1;
    n_cmp++;
    if (rdata !== prev_lo) begin n_err++; $display("FAIL mflo_during_busy: got %h, want %h", rdata, prev_lo); end
    op = 5'd0;
    wait_done("busy_ignore", 27);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL no_extra_done: got %b, want 0", done); end
  endtask

  task automatic test_back_to_back;
    issue(5'd14, 32'd3, 32'd7, 1'b0, 1'b0);
    wait_done("b2b_first", 32);
    issue(5'd13, 32'd100, 32'd7, 1'b0, 1'b1);
    wait_done("b2b_second", 32);
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    issue(5'd13, 32'd1000, 32'd7, 1'b0, 1'b0);
    void'(exp_q.pop_back());
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL rst_mid busy/done: got %b, want 00", {busy, done}); end
    n_cmp++;
    if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL rst_mid hi/lo: got %h, want 0", {hi, lo}); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_err++; $display("FAIL rst_mid no_done: got %0d active cycles, want 0", seen); end
    issue(5'd14, 32'd3, 32'd5, 1'b0, 1'b0);
    wait_done("mult_after_rst", 32);
  endtask

`ifdef SIGNED_MD_EN
  task automatic test_signed;
    issue(5'd14, -32'sd3, 32'd5, 1'b1, 1'b0);
    wait_done("smult_m3x5", 32);
    issue(5'd13, -32'sd7, 32'd2, 1'b1, 1'b0);
    wait_done("sdiv_m7_2", 32);
    issue(5'd13, 32'd7, 32'd2, 1'b1, 1'b0);
    wait_done("sdiv_7_2", 32);
  endtask
`endif

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
`ifdef SIGNED_MD_EN
    test_signed();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
